// File: rtl/byte_mem_arbiter.sv
// Two-requester arbiter that splits byte/half/word accesses into little-endian byte
// transactions on one shared memory. Define MEM_ARB_FIXED_PRIO_EN for fixed m0 priority.
module byte_mem_arbiter #(
   parameter int ADDR_WIDTH     = 12,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_m0_valid,
   input  logic                  i_m0_write,
   input  logic [1:0]            i_m0_size,
   input  logic [ADDR_WIDTH-1:0] i_m0_address,
   input  logic [31:0]           i_m0_wdata,
   output logic                  o_m0_ready,
   output logic                  o_m0_done,
   output logic                  o_m0_err,
   output logic [31:0]           o_m0_rdata,
   input  logic                  i_m1_valid,
   input  logic                  i_m1_write,
   input  logic [1:0]            i_m1_size,
   input  logic [ADDR_WIDTH-1:0] i_m1_address,
   input  logic [31:0]           i_m1_wdata,
   output logic                  o_m1_ready,
   output logic                  o_m1_done,
   output logic                  o_m1_err,
   output logic [31:0]           o_m1_rdata,
   output logic                  o_mem_request,
   output logic                  o_mem_write,
   output logic [ADDR_WIDTH-1:0] o_mem_address,
   output logic [7:0]            o_mem_data,
   input  logic [7:0]            i_mem_data,
   input  logic                  i_mem_data_DV
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t                state_q, state_d;
   logic                  owner_q, owner_d;
   logic                  write_q, write_d;
   logic [1:0]            size_q, size_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [1:0]            idx_q, idx_d;
   logic [31:0]           acc_q, acc_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  mem_request_q, mem_request_d;
   logic                  mem_write_q, mem_write_d;
   logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
   logic [7:0]            mem_data_q, mem_data_d;
   logic                  m0_done_q, m0_done_d, m0_err_q, m0_err_d;
   logic                  m1_done_q, m1_done_d, m1_err_q, m1_err_d;
   logic [31:0]           m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;

   logic                  grant_any, grant_sel;
   logic                  sel_write;
   logic [1:0]            sel_size;
   logic [ADDR_WIDTH-1:0] sel_address;
   logic [31:0]           sel_wdata;
   logic [1:0]            last_idx;
   logic [CW-1:0]         cnt_inc;
   logic                  fin, fin_err;

   assign grant_any = i_m0_valid | i_m1_valid;

`ifdef MEM_ARB_FIXED_PRIO_EN
   assign grant_sel = ~i_m0_valid;
`else
   logic last_grant_q, last_grant_d;

   // A tie goes to whoever was not granted last; a lone requester simply wins.
   assign grant_sel = (i_m0_valid & i_m1_valid) ? ~last_grant_q : ~i_m0_valid;

   always_comb begin
      last_grant_d = last_grant_q;
      if (state_q == IDLE && grant_any) last_grant_d = grant_sel;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) last_grant_q <= 1'b1;
      else         last_grant_q <= last_grant_d;
   end
`endif

   assign sel_write   = grant_sel ? i_m1_write   : i_m0_write;
   assign sel_size    = grant_sel ? i_m1_size    : i_m0_size;
   assign sel_address = grant_sel ? i_m1_address : i_m0_address;
   assign sel_wdata   = grant_sel ? i_m1_wdata   : i_m0_wdata;

   assign o_m0_ready = (state_q == IDLE) & ~i_reset & grant_any & ~grant_sel;
   assign o_m1_ready = (state_q == IDLE) & ~i_reset & grant_any &  grant_sel;

   // Index of the final byte: 0, 1 or 3 for byte, half, word.
   assign last_idx = {size_q[1], size_q[1] | size_q[0]};
   assign cnt_inc  = cnt_q + CW'(1);

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      write_d       = write_q;
      size_d        = size_q;
      base_d        = base_q;
      wdata_d       = wdata_q;
      idx_d         = idx_q;
      acc_d         = acc_q;
      cnt_d         = cnt_q;
      mem_request_d = 1'b0;
      mem_write_d   = mem_write_q;
      mem_address_d = mem_address_q;
      mem_data_d    = mem_data_q;
      m0_done_d     = 1'b0;
      m0_err_d      = 1'b0;
      m0_rdata_d    = m0_rdata_q;
      m1_done_d     = 1'b0;
      m1_err_d      = 1'b0;
      m1_rdata_d    = m1_rdata_q;
      fin           = 1'b0;
      fin_err       = 1'b0;

      case (state_q)
         IDLE: begin
            if (grant_any) begin
               owner_d = grant_sel;
               write_d = sel_write;
               size_d  = sel_size;
               base_d  = sel_address;
               wdata_d = sel_wdata;
               idx_d   = 2'd0;
               acc_d   = '0;
               if (sel_size == 2'd3) begin
                  state_d = DONE;
                  fin     = 1'b1;
                  fin_err = 1'b1;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (i_mem_data_DV) begin
               if (!write_q) acc_d[{idx_q, 3'b000} +: 8] = i_mem_data;
               if (idx_q == last_idx) begin
                  state_d = DONE;
                  fin     = 1'b1;
               end else begin
                  idx_d   = idx_q + 2'd1;
                  state_d = ISSUE;
               end
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == CW'(TIMEOUT_CYCLES)) begin
                  state_d = DONE;
                  fin     = 1'b1;
                  fin_err = 1'b1;
               end
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Memory-side outputs are set up on entry to ISSUE and held through WAIT.
      if (state_d == ISSUE) begin
         mem_request_d = 1'b1;
         mem_write_d   = write_d;
         mem_address_d = base_d + ADDR_WIDTH'(idx_d);
         mem_data_d    = wdata_d[{idx_d, 3'b000} +: 8];
      end else if (state_d != WAIT) begin
         mem_write_d = 1'b0;
      end

      if (fin) begin
         if (owner_d) begin
            m1_done_d  = 1'b1;
            m1_err_d   = fin_err;
            m1_rdata_d = fin_err ? 32'd0 : acc_d;
         end else begin
            m0_done_d  = 1'b1;
            m0_err_d   = fin_err;
            m0_rdata_d = fin_err ? 32'd0 : acc_d;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q       <= IDLE;
         owner_q       <= 1'b0;
         write_q       <= 1'b0;
         size_q        <= 2'd0;
         base_q        <= '0;
         wdata_q       <= '0;
         idx_q         <= 2'd0;
         acc_q         <= '0;
         cnt_q         <= '0;
         mem_request_q <= 1'b0;
         mem_write_q   <= 1'b0;
         mem_address_q <= '0;
         mem_data_q    <= '0;
         m0_done_q     <= 1'b0;
         m0_err_q      <= 1'b0;
         m0_rdata_q    <= '0;
         m1_done_q     <= 1'b0;
         m1_err_q      <= 1'b0;
         m1_rdata_q    <= '0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         write_q       <= write_d;
         size_q        <= size_d;
         base_q        <= base_d;
         wdata_q       <= wdata_d;
         idx_q         <= idx_d;
         acc_q         <= acc_d;
         cnt_q         <= cnt_d;
         mem_request_q <= mem_request_d;
         mem_write_q   <= mem_write_d;
         mem_address_q <= mem_address_d;
         mem_data_q    <= mem_data_d;
         m0_done_q     <= m0_done_d;
         m0_err_q      <= m0_err_d;
         m0_rdata_q    <= m0_rdata_d;
         m1_done_q     <= m1_done_d;
         m1_err_q      <= m1_err_d;
         m1_rdata_q    <= m1_rdata_d;
      end
   end

   assign o_mem_request = mem_request_q;
   assign o_mem_write   = mem_write_q;
   assign o_mem_address = mem_address_q;
   assign o_mem_data    = mem_data_q;
   assign o_m0_done     = m0_done_q;
   assign o_m0_err      = m0_err_q;
   assign o_m0_rdata    = m0_rdata_q;
   assign o_m1_done     = m1_done_q;
   assign o_m1_err      = m1_err_q;
   assign o_m1_rdata    = m1_rdata_q;

endmodule

// File: tb/tb_byte_mem_arbiter.sv
// Bench for byte_mem_arbiter: byte memory slave, a transaction-schedule model checked
// every cycle, and directed accesses with hand-computed results.
module tb_byte_mem_arbiter;
   localparam int AW  = 12;
   localparam int TMO = 15;

   logic          i_clk = 1'b0;
   logic          i_reset = 1'b1;
   logic          i_m0_valid = 1'b0, i_m0_write = 1'b0;
   logic [1:0]    i_m0_size = 2'd0;
   logic [AW-1:0] i_m0_address = '0;
   logic [31:0]   i_m0_wdata = '0;
   logic          i_m1_valid = 1'b0, i_m1_write = 1'b0;
   logic [1:0]    i_m1_size = 2'd0;
   logic [AW-1:0] i_m1_address = '0;
   logic [31:0]   i_m1_wdata = '0;
   logic          o_m0_ready, o_m0_done, o_m0_err, o_m1_ready, o_m1_done, o_m1_err;
   logic [31:0]   o_m0_rdata, o_m1_rdata;
   logic          o_mem_request, o_mem_write;
   logic [AW-1:0] o_mem_address;
   logic [7:0]    o_mem_data;
   logic [7:0]    i_mem_data;
   logic          i_mem_data_DV = 1'b0;

   byte_mem_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_m0_valid(i_m0_valid), .i_m0_write(i_m0_write), .i_m0_size(i_m0_size),
      .i_m0_address(i_m0_address), .i_m0_wdata(i_m0_wdata),
      .o_m0_ready(o_m0_ready), .o_m0_done(o_m0_done), .o_m0_err(o_m0_err), .o_m0_rdata(o_m0_rdata),
      .i_m1_valid(i_m1_valid), .i_m1_write(i_m1_write), .i_m1_size(i_m1_size),
      .i_m1_address(i_m1_address), .i_m1_wdata(i_m1_wdata),
      .o_m1_ready(o_m1_ready), .o_m1_done(o_m1_done), .o_m1_err(o_m1_err), .o_m1_rdata(o_m1_rdata),
      .o_mem_request(o_mem_request), .o_mem_write(o_mem_write),
      .o_mem_address(o_mem_address), .o_mem_data(o_mem_data),
      .i_mem_data(i_mem_data), .i_mem_data_DV(i_mem_data_DV)
   );

   always #5 i_clk = ~i_clk;

   int cyc = 0;
   int req_cnt = 0;
   int checks = 0, errors = 0;
   always @(posedge i_clk) cyc <= cyc + 1;
   always @(negedge i_clk) if (o_mem_request) req_cnt++;

   // Byte memory slave: read is combinational, DV follows a sampled request by one cycle.
   logic [7:0] smem [0:4095];
   logic       dv_en = 1'b1;
   always @(posedge i_clk) begin
      i_mem_data_DV <= o_mem_request & dv_en;
      if (o_mem_request && o_mem_write) smem[o_mem_address] <= o_mem_data;
   end
   assign i_mem_data = smem[o_mem_address];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, actual, expected);
      end
   endtask

   // Model: on each grant, lay out the whole access as a timeline of expected byte
   // requests and one done event, from the address/size/latency rules alone.
   typedef struct packed {logic wr; logic [AW-1:0] a; logic [7:0] d;} req_t;
   typedef struct packed {logic g; logic err; logic [31:0] rd;} done_t;
   req_t       exp_req [int];
   done_t      exp_done [int];
   logic [7:0] gmem [0:4095];
   int         free_cyc = 0, act_lo = 0, act_hi = -1;
   logic       act_wr = 1'b0, m_lg = 1'b1;
   logic [31:0] held0 = '0, held1 = '0;

   always @(negedge i_clk) begin
      logic acc, g, wr;
      logic [1:0] sz;
      logic [AW-1:0] ad;
      logic [31:0] wd, rd;
      int n, t_done;
      req_t r;
      done_t dn;
      if (cyc >= 1) begin
         acc = 1'b0;
         g   = 1'b0;
         if (!i_reset && cyc >= free_cyc && (i_m0_valid || i_m1_valid)) begin
            acc = 1'b1;
`ifdef MEM_ARB_FIXED_PRIO_EN
            g = !i_m0_valid;
`else
            g = (i_m0_valid && i_m1_valid) ? !m_lg : !i_m0_valid;
            m_lg = g;
`endif
            wr = g ? i_m1_write : i_m0_write;
            sz = g ? i_m1_size : i_m0_size;
            ad = g ? i_m1_address : i_m0_address;
            wd = g ? i_m1_wdata : i_m0_wdata;
            if (sz == 2'd3) begin
               exp_done[cyc + 1] = '{g, 1'b1, 32'd0};
               act_lo   = 0;
               act_hi   = -1;
               free_cyc = cyc + 2;
            end else begin
               n      = 1 << sz;
               act_lo = cyc + 1;
               act_wr = wr;
               if (dv_en) begin
                  rd = '0;
                  for (int k = 0; k < n; k++) begin
                     exp_req[cyc + 1 + 2 * k] = '{wr, AW'(ad + k), wd[8 * k +: 8]};
                     if (!wr) rd[8 * k +: 8] = gmem[AW'(ad + k)];
                  end
                  t_done = cyc + 1 + 2 * n;
                  exp_done[t_done] = '{g, 1'b0, rd};
               end else begin
                  exp_req[cyc + 1] = '{wr, ad, wd[7:0]};
                  t_done = cyc + 2 + TMO;
                  exp_done[t_done] = '{g, 1'b1, 32'd0};
               end
               act_hi   = t_done - 1;
               free_cyc = t_done + 1;
            end
         end

         checkOutput("ready0", {31'd0, o_m0_ready}, {31'd0, acc && !g});
         checkOutput("ready1", {31'd0, o_m1_ready}, {31'd0, acc && g});
         checkOutput("mem_request", {31'd0, o_mem_request}, {31'd0, exp_req.exists(cyc) != 0});
         if (exp_req.exists(cyc)) begin
            r = exp_req[cyc];
            checkOutput("mem_address", {20'd0, o_mem_address}, {20'd0, r.a});
            checkOutput("mem_data", {24'd0, o_mem_data}, {24'd0, r.d});
            if (r.wr) gmem[r.a] = r.d;
         end
         if (cyc >= act_lo && cyc <= act_hi)
            checkOutput("mem_write", {31'd0, o_mem_write}, {31'd0, act_wr});
         else
            checkOutput("mem_write_idle", {31'd0, o_mem_write}, 32'd0);

         if (exp_done.exists(cyc)) begin
            dn = exp_done[cyc];
            if (dn.g) held1 = dn.rd;
            else      held0 = dn.rd;
            checkOutput("m0_done", {31'd0, o_m0_done}, {31'd0, !dn.g});
            checkOutput("m1_done", {31'd0, o_m1_done}, {31'd0, dn.g});
            checkOutput("err", {31'd0, dn.g ? o_m1_err : o_m0_err}, {31'd0, dn.err});
         end else begin
            checkOutput("m0_done_idle", {31'd0, o_m0_done}, 32'd0);
            checkOutput("m1_done_idle", {31'd0, o_m1_done}, 32'd0);
         end
         checkOutput("m0_rdata", o_m0_rdata, held0);
         checkOutput("m1_rdata", o_m1_rdata, held1);

         if (i_reset) begin
            exp_req.delete();
            exp_done.delete();
            free_cyc = cyc + 1;
            m_lg     = 1'b1;
            held0    = '0;
            held1    = '0;
            act_lo   = 0;
            act_hi   = -1;
         end
      end
   end

   task automatic drive(input int m, input logic v, input logic wr, input logic [1:0] sz,
                        input logic [AW-1:0] a, input logic [31:0] wd);
      if (m == 0) begin
         i_m0_valid = v; i_m0_write = wr; i_m0_size = sz; i_m0_address = a; i_m0_wdata = wd;
      end else begin
         i_m1_valid = v; i_m1_write = wr; i_m1_size = sz; i_m1_address = a; i_m1_wdata = wd;
      end
   endtask

   // One access on requester m; returns latency from ready to done, result and request count.
   task automatic applyStimulus(input int m, input logic wr, input logic [1:0] sz,
                                input logic [AW-1:0] a, input logic [31:0] wd,
                                output int lat, output logic [31:0] rd, output logic er,
                                output int nreq);
      int t0 = -1;
      int base;
      bit seen = 1'b0;
      lat = -1; rd = '0; er = 1'b0; nreq = 0;
      @(posedge i_clk); #1;
      drive(m, 1'b1, wr, sz, a, wd);
      base = req_cnt;
      for (int i = 0; i < 40 && t0 < 0; i++) begin
         @(negedge i_clk);
         if ((m == 0) ? o_m0_ready : o_m1_ready) t0 = cyc;
      end
      @(posedge i_clk); #1;
      drive(m, 1'b0, 1'b0, 2'd0, '0, '0);
      if (t0 < 0) begin
         checkOutput("ready_seen", 32'd0, 32'd1);
         return;
      end
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge i_clk);
         if ((m == 0) ? o_m0_done : o_m1_done) begin
            seen = 1'b1;
            lat  = cyc - t0;
            rd   = (m == 0) ? o_m0_rdata : o_m1_rdata;
            er   = (m == 0) ? o_m0_err : o_m1_err;
         end
      end
      nreq = req_cnt - base;
      if (!seen) checkOutput("done_seen", 32'd0, 32'd1);
   endtask

   task automatic applyReset();
      @(posedge i_clk); #1;
      drive(0, 1'b0, 1'b0, 2'd0, '0, '0);
      drive(1, 1'b0, 1'b0, 2'd0, '0, '0);
      i_reset = 1'b1;
      repeat (2) @(posedge i_clk);
      #1 i_reset = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int lat, nreq, t0, base, ng;
      logic [31:0] rd;
      logic er;
      int order [4];
      for (int i = 0; i < 4096; i++) begin
         smem[i] = 8'(i * 37 + 11);
         gmem[i] = 8'(i * 37 + 11);
      end
      repeat (3) @(posedge i_clk);
      #1 i_reset = 1'b0;
      @(negedge i_clk);
      checkOutput("reset_request", {31'd0, o_mem_request}, 32'd0);
      checkOutput("reset_done", {30'd0, o_m0_done, o_m1_done}, 32'd0);
      checkOutput("reset_address", {20'd0, o_mem_address}, 32'd0);

      $display("[TB] word store 0xA5A55A5A @4");
      applyStimulus(0, 1'b1, 2'd2, 12'd4, 32'hA5A55A5A, lat, rd, er, nreq);
      checkOutput("wstore_latency", lat, 9);
      checkOutput("wstore_err", {31'd0, er}, 32'd0);
      checkOutput("wstore_requests", nreq, 4);
      checkOutput("wstore_bytes", {smem[7], smem[6], smem[5], smem[4]}, 32'hA5A55A5A);

      $display("[TB] word load @4");
      applyStimulus(0, 1'b0, 2'd2, 12'd4, 32'd0, lat, rd, er, nreq);
      checkOutput("wload_latency", lat, 9);
      checkOutput("wload_rdata", rd, 32'hA5A55A5A);

      $display("[TB] half store 0x1234 @4095 (wrap)");
      applyStimulus(0, 1'b1, 2'd1, 12'd4095, 32'h00001234, lat, rd, er, nreq);
      checkOutput("wrap_latency", lat, 5);
      checkOutput("wrap_byte_4095", {24'd0, smem[4095]}, 32'h34);
      checkOutput("wrap_byte_0", {24'd0, smem[0]}, 32'h12);

      $display("[TB] reserved size");
      applyStimulus(1, 1'b0, 2'd3, 12'h010, 32'd0, lat, rd, er, nreq);
      checkOutput("rsvd_latency", lat, 1);
      checkOutput("rsvd_err", {31'd0, er}, 32'd1);
      checkOutput("rsvd_requests", nreq, 0);

      $display("[TB] m1 half load with DV stuck low");
      dv_en = 1'b0;
      applyStimulus(1, 1'b0, 2'd1, 12'h020, 32'd0, lat, rd, er, nreq);
      dv_en = 1'b1;
      checkOutput("tmo_latency", lat, 17);
      checkOutput("tmo_err", {31'd0, er}, 32'd1);
      checkOutput("tmo_rdata", rd, 32'd0);
      checkOutput("tmo_requests", nreq, 1);

      $display("[TB] byte load @7");
      applyStimulus(0, 1'b0, 2'd0, 12'd7, 32'd0, lat, rd, er, nreq);
      checkOutput("bload_latency", lat, 3);
      checkOutput("bload_rdata", rd, 32'h000000A5);

      $display("[TB] reset during third byte of a word store");
      @(posedge i_clk); #1;
      drive(0, 1'b1, 1'b1, 2'd2, 12'd8, 32'hDEADBEEF);
      base = req_cnt;
      t0 = -1;
      for (int i = 0; i < 40 && t0 < 0; i++) begin
         @(negedge i_clk);
         if (o_m0_ready) t0 = cyc;
      end
      @(posedge i_clk); #1;
      drive(0, 1'b0, 1'b0, 2'd0, '0, '0);
      for (int i = 0; i < 40 && (req_cnt - base) < 3; i++) @(negedge i_clk);
      checkOutput("mid_third_request", req_cnt - base, 3);
      @(posedge i_clk); #1 i_reset = 1'b1;
      @(posedge i_clk); #1 i_reset = 1'b0;
      @(negedge i_clk);
      checkOutput("mid_request", {31'd0, o_mem_request}, 32'd0);
      checkOutput("mid_address", {20'd0, o_mem_address}, 32'd0);
      checkOutput("mid_data", {24'd0, o_mem_data}, 32'd0);
      checkOutput("mid_rdata", o_m0_rdata, 32'd0);
      checkOutput("mid_third_byte", {24'd0, smem[10]}, 32'hAD);

      applyStimulus(1, 1'b0, 2'd0, 12'd5, 32'd0, lat, rd, er, nreq);
      checkOutput("after_latency", lat, 3);
      checkOutput("after_rdata", rd, 32'h0000005A);
      checkOutput("after_err", {31'd0, er}, 32'd0);

      $display("[TB] both requesters valid from reset");
      applyReset();
      @(posedge i_clk); #1;
      drive(0, 1'b1, 1'b0, 2'd0, 12'd4, 32'd0);
      drive(1, 1'b1, 1'b0, 2'd0, 12'd5, 32'd0);
      ng = 0;
      for (int i = 0; i < 60 && ng < 4; i++) begin
         @(negedge i_clk);
         if (o_m0_ready) begin order[ng] = 0; ng++; end
         else if (o_m1_ready) begin order[ng] = 1; ng++; end
      end
      @(posedge i_clk); #1;
      drive(0, 1'b0, 1'b0, 2'd0, '0, '0);
      drive(1, 1'b0, 1'b0, 2'd0, '0, '0);
      checkOutput("grant_count", ng, 4);
      for (int k = 0; k < ng; k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
         checkOutput("grant_order", order[k], 0);
`else
         checkOutput("grant_order", order[k], k % 2);
`endif
      end
      repeat (8) @(posedge i_clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/byte_mem_arbiter.md
Name: byte_mem_arbiter

Overview:
- Shares one byte-wide, single-port memory slave (request/write/address/data in; data + data-valid out) between two requesters, for example the CPU load/store unit and a debug loader.
- Converts each requester's byte, halfword or word access into a sequence of single-byte memory transactions, little-endian.
- Round-robin arbitration between the two requesters.
- Watchdog aborts any byte transaction whose data-valid never returns.

Parameters:
- ADDR_WIDTH, 12, byte address width on both sides.
- TIMEOUT_CYCLES, 15, number of WAIT cycles without i_mem_data_DV before the access aborts; must be at least 1.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_m0_valid  in  1  requester 0 has an access pending.
- i_m0_write  in  1  1 = store, 0 = load.
- i_m0_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- i_m0_address  in  ADDR_WIDTH  byte address of byte 0.
- i_m0_wdata  in  32  store data; bits [7:0] go to the address.
- o_m0_ready  out  1  access accepted this cycle.
- o_m0_done  out  1  one-cycle completion pulse.
- o_m0_err  out  1  valid with done; timeout or reserved size.
- o_m0_rdata  out  32  load result, zero-extended, valid with done.
- i_m1_* / o_m1_*  same set as m0  requester 1.
- o_mem_request  out  1  byte transaction strobe to the memory.
- o_mem_write  out  1  byte write enable.
- o_mem_address  out  ADDR_WIDTH  byte address.
- o_mem_data  out  8  write byte.
- i_mem_data  in  8  read byte; combinational from o_mem_address.
- i_mem_data_DV  in  1  completion, one cycle after the request is sampled.

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE.
- Reset values: state IDLE; all o_* = 0; last_grant = 1, so m0 wins the first tie.
- IDLE:
  - Any valid: grant one requester and pulse its o_mX_ready for 1 cycle.
  - Latch write, size, address and wdata; byte index = 0; rdata accumulator = 0.
  - Tie: grant the requester opposite last_grant, then update last_grant.
  - Size 3: skip memory, go to DONE with err = 1.
  - Otherwise go to ISSUE.
- ISSUE (1 cycle):
  - o_mem_request = 1.
  - o_mem_address = latched address + index, modulo 2^ADDR_WIDTH (wraps 4095 -> 0).
  - o_mem_data = wdata[8*index +: 8]; o_mem_write = latched write.
  - Timeout counter cleared. Go to WAIT.
- WAIT:
  - o_mem_request = 0; address, data and write held.
  - i_mem_data_DV = 1:
    - On a load, capture i_mem_data into rdata[8*index +: 8].
    - Last byte (index == 2^size - 1): go to DONE.
    - Otherwise increment index and go to ISSUE.
  - i_mem_data_DV = 0: increment the counter. When it reaches TIMEOUT_CYCLES, go to DONE with err = 1 and rdata = 0.
- DONE (1 cycle):
  - Granted requester's o_mX_done = 1, plus err; o_mX_rdata driven.
  - o_mX_rdata holds until that requester's next done.
  - Stores return rdata = 0. Go to IDLE.
- Latency for an access accepted in cycle T with N bytes: done in cycle T+1+2N (byte T+3, half T+5, word T+9). Reserved size: done at T+1.
- A requester must hold valid and its fields until it sees ready. Fields are ignored after ready.
- A new access is accepted only in IDLE, so throughput is one access per 2N+2 cycles.
- Outside ISSUE/WAIT: o_mem_request = 0 and o_mem_write = 0; address and data are don't-care but held stable.
- i_mem_data_DV in IDLE, ISSUE or DONE is ignored.
- A DV arriving in the same cycle as the timeout limit counts as success.
- Reset mid-operation: IDLE on the next edge, no done pulse, rdata cleared. Byte writes already strobed may still commit in memory.

Optional Feature:
- Macro MEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; m0 always wins ties; last_grant unused.
- Undefined (default): round-robin as above.

Test Plan:
- Reset, m0 word store 0xA5A55A5A at address 4 -> bytes 4..7 = 5A, 5A, A5, A5; exactly 4 o_mem_request pulses two cycles apart; done at T+9 with err = 0.
- m0 word load from address 4 after the previous store -> o_m0_rdata = 0xA5A55A5A at T+9. Byte load from address 7 -> 0x000000A5 at T+3.
- m0 and m1 valid every cycle from reset -> ready order m0, m1, m0, m1. With MEM_ARB_FIXED_PRIO_EN, only m0 is granted while it stays valid.
- Memory model with DV tied low; m1 half load -> done with err = 1 and rdata = 0 exactly 15 WAIT cycles after the ISSUE.
- Half store 0x1234 at address 4095 -> address 4095 gets 0x34, address 0 gets 0x12 (wrap). Size 3 -> err at T+1 with no o_mem_request.
- Assert i_reset during the third byte of a word store -> next cycle IDLE, all outputs 0, no done; a following m1 byte access completes normally.
